// File: rtl/mem_arbiter_if.sv
// Cache-to-memory bundle: dcache and icache request ports plus the single RAM port.
// The arbiter takes the slave side; the caches/RAM model take the master side.
interface mem_arbiter_if;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        memerr;

  modport slave (
    input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    output dload, dwait, iload, iwait, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  modport master (
    output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    input  dload, dwait, iload, iwait, ramREN, ramWEN, ramaddr, ramstore, memerr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates dcache (priority) and icache word requests onto one variable-latency RAM port.
// Request seen in IDLE -> RAM strobes next cycle -> wait low on first ACCESS; RAM BUSY/FREE holds service.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;

  state_t        state;
  logic [CW-1:0] starveCnt;
  logic [31:0]   reqAddr;
  logic [31:0]   reqStore;
  logic          reqWrite;
  logic          memErr;

  logic dReq, dGrant, dServ, iServ;

  assign dReq   = bus.dREN | bus.dWEN;
  // dcache yields only once it has starved a waiting icache for LIMIT grants
  assign dGrant = dReq && !((starveCnt == LIMIT) && bus.iREN);
  assign dServ  = (state == DSERV);
  assign iServ  = (state == ISERV);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      starveCnt <= '0;
      reqAddr   <= '0;
      reqStore  <= '0;
      reqWrite  <= 1'b0;
      memErr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dGrant) begin
            state    <= DSERV;
            reqAddr  <= bus.daddr;
            reqStore <= bus.dstore;
            reqWrite <= bus.dWEN;
            if (!bus.iREN)
              starveCnt <= '0;
            else if (starveCnt != LIMIT)
              starveCnt <= starveCnt + CW'(1);
          end else if (bus.iREN) begin
            state     <= ISERV;
            reqAddr   <= bus.iaddr;
            reqWrite  <= 1'b0;
            starveCnt <= '0;
          end
        end
        DSERV: begin
          if (!dReq || bus.ramstate == RAM_ACCESS) begin
            state <= IDLE;
          end else if (bus.ramstate == RAM_ERROR) begin
            memErr <= 1'b1;
            state  <= IDLE;
          end
        end
        ISERV: begin
          if (!bus.iREN || bus.ramstate == RAM_ACCESS) begin
            state <= IDLE;
          end else if (bus.ramstate == RAM_ERROR) begin
            memErr <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM port is decoded from registered state and latched request only
  assign bus.ramREN   = (dServ && !reqWrite) || iServ;
  assign bus.ramWEN   = dServ && reqWrite;
  assign bus.ramaddr  = (dServ || iServ) ? reqAddr : '0;
  assign bus.ramstore = (dServ && reqWrite) ? reqStore : '0;

  assign bus.dwait  = !(dServ && dReq && bus.ramstate == RAM_ACCESS);
  assign bus.iwait  = !(iServ && bus.iREN && bus.ramstate == RAM_ACCESS);
  assign bus.dload  = dServ ? bus.ramload : '0;
  assign bus.iload  = iServ ? bus.ramload : '0;
  assign bus.memerr = memErr;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, starvation/reset sequences, and randomized
// traffic checked cycle-by-cycle against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int LIMIT = 4;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic CLK;
  logic nRST;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  typedef struct packed {
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        iREN;
    logic [31:0] iaddr;
    logic [1:0]  rs;
    logic [31:0] rl;
  } in_t;

  typedef struct packed {
    logic        dwait;
    logic        iwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] dload;
    logic [31:0] iload;
    logic        memerr;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  int   tests = 0;
  int   failed = 0;
  in_t  cur;
  vec_t tbl[$];

  // Reference model: who is being served (0 none, 1 dcache, 2 icache) and the captured request
  int          srv;
  int          starve;
  logic [31:0] mAddr;
  logic [31:0] mStore;
  logic        mWrite;
  logic        mErr;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic in_t mkIn(input logic dr, input logic dw, input logic [31:0] da,
                               input logic [31:0] ds, input logic ir, input logic [31:0] ia,
                               input logic [1:0] rs, input logic [31:0] rl);
    in_t v;
    v.dREN = dr; v.dWEN = dw; v.daddr = da; v.dstore = ds;
    v.iREN = ir; v.iaddr = ia; v.rs = rs; v.rl = rl;
    return v;
  endfunction

  function automatic out_t mkOut(input logic dw, input logic iw, input logic ren, input logic wen,
                                 input logic [31:0] a, input logic [31:0] st, input logic [31:0] dl,
                                 input logic [31:0] il, input logic me);
    out_t o;
    o.dwait = dw; o.iwait = iw; o.ramREN = ren; o.ramWEN = wen; o.ramaddr = a;
    o.ramstore = st; o.dload = dl; o.iload = il; o.memerr = me;
    return o;
  endfunction

  function automatic out_t idleOut(input logic me);
    return mkOut(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, me);
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("dwait=%b iwait=%b ramREN=%b ramWEN=%b ramaddr=%h ramstore=%h dload=%h iload=%h memerr=%b",
                     o.dwait, o.iwait, o.ramREN, o.ramWEN, o.ramaddr, o.ramstore, o.dload, o.iload, o.memerr);
  endfunction

  function automatic out_t getOut();
    return mkOut(bus.dwait, bus.iwait, bus.ramREN, bus.ramWEN, bus.ramaddr,
                 bus.ramstore, bus.dload, bus.iload, bus.memerr);
  endfunction

  task automatic applyIn(input in_t v);
    cur          = v;
    bus.dREN     = v.dREN;
    bus.dWEN     = v.dWEN;
    bus.daddr    = v.daddr;
    bus.dstore   = v.dstore;
    bus.iREN     = v.iREN;
    bus.iaddr    = v.iaddr;
    bus.ramstate = v.rs;
    bus.ramload  = v.rl;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = getOut();
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %s ; expected %s", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic addVec(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    tbl.push_back(v);
  endtask

  task automatic doReset();
    nRST = 1'b0;
    applyIn('0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic modelReset();
    srv = 0; starve = 0; mAddr = '0; mStore = '0; mWrite = 1'b0; mErr = 1'b0;
  endtask

  function automatic out_t modelOut(input in_t v);
    out_t o;
    logic dq;
    dq         = v.dREN | v.dWEN;
    o.dwait    = !(srv == 1 && dq && v.rs == ACCESS);
    o.iwait    = !(srv == 2 && v.iREN && v.rs == ACCESS);
    o.ramREN   = (srv == 1 && !mWrite) || srv == 2;
    o.ramWEN   = (srv == 1 && mWrite);
    o.ramaddr  = (srv != 0) ? mAddr : 32'h0;
    o.ramstore = (srv == 1 && mWrite) ? mStore : 32'h0;
    o.dload    = (srv == 1) ? v.rl : 32'h0;
    o.iload    = (srv == 2) ? v.rl : 32'h0;
    o.memerr   = mErr;
    return o;
  endfunction

  task automatic modelStep(input in_t v);
    logic dq;
    logic req;
    dq = v.dREN | v.dWEN;
    if (srv == 0) begin
      if (dq && !(starve == LIMIT && v.iREN)) begin
        srv = 1; mAddr = v.daddr; mStore = v.dstore; mWrite = v.dWEN;
        starve = v.iREN ? ((starve + 1 > LIMIT) ? LIMIT : starve + 1) : 0;
      end else if (v.iREN) begin
        srv = 2; mAddr = v.iaddr; mWrite = 1'b0; starve = 0;
      end
    end else begin
      req = (srv == 1) ? dq : v.iREN;
      if (!req || v.rs == ACCESS) begin
        srv = 0;
      end else if (v.rs == ERROR) begin
        mErr = 1'b1;
        srv  = 0;
      end
    end
  endtask

  function automatic in_t nextRand(input in_t p);
    in_t n;
    int  r;
    n = p;
    if ($urandom_range(9) == 0)  n.dREN = ~n.dREN;
    if ($urandom_range(11) == 0) n.dWEN = ~n.dWEN;
    if ($urandom_range(9) == 0)  n.iREN = ~n.iREN;
    n.daddr  = $urandom;
    n.dstore = $urandom;
    n.iaddr  = $urandom;
    n.rl     = $urandom;
    r = $urandom_range(99);
    n.rs = (r < 20) ? FREE : (r < 50) ? BUSY : (r < 95) ? ACCESS : ERROR;
    return n;
  endfunction

  initial begin
    int grants[$];
    int expGrants[6];

    nRST = 1'b0;
    applyIn('0);
    #3;
    check("reset_values", idleOut(1'b0));
    @(negedge CLK);
    nRST = 1'b1;

    // dcache read with two BUSY cycles
    addVec(mkIn(0, 0, 32'h0,   32'h0, 0, 32'h0, FREE,   32'h0),        idleOut(0));
    addVec(mkIn(1, 0, 32'h100, 32'h0, 0, 32'h0, FREE,   32'h0),        idleOut(0));
    addVec(mkIn(1, 0, 32'h100, 32'h0, 0, 32'h0, BUSY,   32'h0),        mkOut(1, 1, 1, 0, 32'h100, 0, 0, 0, 0));
    addVec(mkIn(1, 0, 32'h100, 32'h0, 0, 32'h0, BUSY,   32'h0),        mkOut(1, 1, 1, 0, 32'h100, 0, 0, 0, 0));
    addVec(mkIn(1, 0, 32'h100, 32'h0, 0, 32'h0, ACCESS, 32'hDEADBEEF), mkOut(0, 1, 1, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0));
    addVec(mkIn(0, 0, 32'h0,   32'h0, 0, 32'h0, FREE,   32'h0),        idleOut(0));
    // simultaneous dcache write and icache read: write first, one IDLE, then fetch
    addVec(mkIn(0, 1, 32'h200, 32'h12345678, 1, 32'h40, ACCESS, 32'h0), idleOut(0));
    addVec(mkIn(0, 1, 32'h200, 32'h12345678, 1, 32'h40, ACCESS, 32'h0), mkOut(0, 1, 0, 1, 32'h200, 32'h12345678, 0, 0, 0));
    addVec(mkIn(0, 0, 32'h0,   32'h0, 1, 32'h40, ACCESS, 32'h0),        idleOut(0));
    addVec(mkIn(0, 0, 32'h0,   32'h0, 1, 32'h40, ACCESS, 32'hCAFEF00D), mkOut(1, 0, 1, 0, 32'h40, 0, 0, 32'hCAFEF00D, 0));
    addVec(mkIn(0, 0, 32'h0,   32'h0, 0, 32'h0,  FREE,   32'h0),        idleOut(0));
    // abort in second DSERV cycle: strobes drop, no completion even when ACCESS follows
    addVec(mkIn(1, 0, 32'h300, 32'h0, 0, 32'h0, BUSY,   32'h0),        idleOut(0));
    addVec(mkIn(1, 0, 32'h300, 32'h0, 0, 32'h0, BUSY,   32'h0),        mkOut(1, 1, 1, 0, 32'h300, 0, 0, 0, 0));
    addVec(mkIn(0, 0, 32'h300, 32'h0, 0, 32'h0, BUSY,   32'h0),        mkOut(1, 1, 1, 0, 32'h300, 0, 0, 0, 0));
    addVec(mkIn(0, 0, 32'h0,   32'h0, 0, 32'h0, ACCESS, 32'h11111111), idleOut(0));
    // RAM error: sticky flag, retry, then normal completion
    addVec(mkIn(1, 0, 32'h500, 32'h0, 0, 32'h0, FREE,   32'h0),        idleOut(0));
    addVec(mkIn(1, 0, 32'h500, 32'h0, 0, 32'h0, ERROR,  32'h0),        mkOut(1, 1, 1, 0, 32'h500, 0, 0, 0, 0));
    addVec(mkIn(1, 0, 32'h500, 32'h0, 0, 32'h0, BUSY,   32'h0),        idleOut(1));
    addVec(mkIn(1, 0, 32'h500, 32'h0, 0, 32'h0, ACCESS, 32'hABCD0123), mkOut(0, 1, 1, 0, 32'h500, 0, 32'hABCD0123, 0, 1));
    addVec(mkIn(0, 0, 32'h0,   32'h0, 0, 32'h0, FREE,   32'h0),        idleOut(1));

    foreach (tbl[k]) begin
      @(posedge CLK);
      #1;
      applyIn(tbl[k].i);
      #4;
      check($sformatf("vector_%0d", k), tbl[k].o);
    end

    // starvation: dcache and icache both requesting continuously
    doReset();
    applyIn(mkIn(1, 0, 32'h900, 32'h0, 1, 32'h80, ACCESS, 32'h0));
    for (int c = 0; c < 40 && grants.size() < 6; c++) begin
      @(posedge CLK);
      #5;
      if (!bus.dwait)      grants.push_back(1);
      else if (!bus.iwait) grants.push_back(2);
    end
    expGrants = '{1, 1, 1, 1, 2, 1};
    for (int g = 0; g < 6; g++) begin
      int got;
      got = (g < grants.size()) ? grants[g] : 0;
      tests++;
      if (got != expGrants[g]) begin
        failed++;
        $display("FAIL starve_grant_%0d: got requester %0d, expected %0d (1=dcache 2=icache 0=none)",
                 g + 1, got, expGrants[g]);
      end
    end

    // reset pulsed during icache service
    doReset();
    applyIn(mkIn(0, 0, 32'h0, 32'h0, 1, 32'h44, BUSY, 32'h0));
    @(posedge CLK);
    #5;
    check("iserv_busy", mkOut(1, 1, 1, 0, 32'h44, 0, 0, 0, 0));
    nRST = 1'b0;
    applyIn(mkIn(0, 0, 32'h0, 32'h0, 1, 32'h44, ACCESS, 32'h5555AAAA));
    #1;
    check("reset_async", idleOut(0));
    @(posedge CLK);
    #1;
    check("reset_hold", idleOut(0));
    nRST = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK);
      #4;
      if (!bus.iwait) break;
    end
    check("iserv_after_reset", mkOut(1, 0, 1, 0, 32'h44, 0, 0, 32'h5555AAAA, 0));

    // randomized traffic against the reference model
    doReset();
    modelReset();
    for (int k = 0; k < 3000; k++) begin
      @(posedge CLK);
      #1;
      applyIn(nextRand(cur));
      #4;
      check($sformatf("random_%0d", k), modelOut(cur));
      modelStep(cur);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
